mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter granting one client burst at a time to a
// single memory port. Each grant goes IDLE -> REQ -> (RD | WR) -> IDLE, and
// bursts are never interleaved.
module mem_arbiter #(
   parameter int NUM_CLIENTS   = 2,
   parameter int MEM_LEN_BITS  = 8,
   parameter int MEM_ADDR_BITS = 64,
   parameter int MEM_DATA_BITS = 64
) (
   input  logic                                   clock,
   input  logic                                   reset,

   input  logic [NUM_CLIENTS-1:0]                 cl_req_valid,
   output logic [NUM_CLIENTS-1:0]                 cl_req_ready,
   input  logic [NUM_CLIENTS-1:0]                 cl_req_opcode,
   input  logic [NUM_CLIENTS*MEM_LEN_BITS-1:0]    cl_req_len,
   input  logic [NUM_CLIENTS*MEM_ADDR_BITS-1:0]   cl_req_addr,
   input  logic [NUM_CLIENTS-1:0]                 cl_wr_valid,
   input  logic [NUM_CLIENTS*MEM_DATA_BITS-1:0]   cl_wr_bits,
   output logic [NUM_CLIENTS-1:0]                 cl_rd_valid,
   output logic [MEM_DATA_BITS-1:0]               cl_rd_bits,
   input  logic [NUM_CLIENTS-1:0]                 cl_rd_ready,

   output logic                                   mem_req_valid,
   output logic                                   mem_req_opcode,
   output logic [MEM_LEN_BITS-1:0]                mem_req_len,
   output logic [MEM_ADDR_BITS-1:0]               mem_req_addr,
   output logic                                   mem_wr_valid,
   output logic [MEM_DATA_BITS-1:0]               mem_wr_bits,
   input  logic                                   mem_rd_valid,
   input  logic [MEM_DATA_BITS-1:0]               mem_rd_bits,
   output logic                                   mem_rd_ready,

   output logic                                   busy,
   output logic [2:0]                             grant_id
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RD   = 2'd2,
      WR   = 2'd3
   } state_t;

   state_t                   r_state;
   logic [2:0]               r_ptr;
   logic [2:0]               r_owner;
   logic [MEM_LEN_BITS-1:0]  r_cnt;
   logic                     r_op;
   logic [MEM_LEN_BITS-1:0]  r_len;
   logic [MEM_ADDR_BITS-1:0] r_addr;

   logic                     w_found;
   logic [2:0]               w_winner;
   logic [2:0]               w_ptrNext;
   logic                     w_winOp;
   logic [MEM_LEN_BITS-1:0]  w_winLen;
   logic [MEM_ADDR_BITS-1:0] w_winAddr;
   logic                     w_selRdReady;
   logic                     w_selWrValid;
   logic [MEM_DATA_BITS-1:0] w_selWrBits;
   logic                     w_rdBeat;
   logic                     w_wrBeat;

   // Round-robin search: try ptr, ptr+1, ... wrapping at NUM_CLIENTS, first valid wins.
   always_comb begin
      int cand;
      int nxt;
      cand      = 0;
      nxt       = 0;
      w_found   = 1'b0;
      w_winner  = 3'd0;
      w_ptrNext = 3'd0;
      for (int j = 0; j < NUM_CLIENTS; j++) begin
         cand = int'(r_ptr) + j;
         if (cand >= NUM_CLIENTS) begin
            cand = cand - NUM_CLIENTS;
         end
         for (int k = 0; k < NUM_CLIENTS; k++) begin
            if (!w_found && (k == cand) && cl_req_valid[k]) begin
               w_found  = 1'b1;
               w_winner = 3'(k);
            end
         end
      end
      nxt = int'(w_winner) + 1;
      if (nxt >= NUM_CLIENTS) begin
         nxt = 0;
      end
      w_ptrNext = 3'(nxt);
   end

   // Pull the winner's request fields out of the flattened per-client buses.
   always_comb begin
      w_winOp   = 1'b0;
      w_winLen  = '0;
      w_winAddr = '0;
      for (int k = 0; k < NUM_CLIENTS; k++) begin
         if (w_winner == 3'(k)) begin
            w_winOp   = cl_req_opcode[k];
            w_winLen  = cl_req_len[k*MEM_LEN_BITS +: MEM_LEN_BITS];
            w_winAddr = cl_req_addr[k*MEM_ADDR_BITS +: MEM_ADDR_BITS];
         end
      end
   end

   // Route the current owner's data-phase handshake signals; other clients are ignored.
   always_comb begin
      w_selRdReady = 1'b0;
      w_selWrValid = 1'b0;
      w_selWrBits  = '0;
      for (int k = 0; k < NUM_CLIENTS; k++) begin
         if (r_owner == 3'(k)) begin
            w_selRdReady = cl_rd_ready[k];
            w_selWrValid = cl_wr_valid[k];
            w_selWrBits  = cl_wr_bits[k*MEM_DATA_BITS +: MEM_DATA_BITS];
         end
      end
   end

   // Request accept is combinational in IDLE so a client sees the grant in its request cycle.
   always_comb begin
      cl_req_ready = '0;
      for (int k = 0; k < NUM_CLIENTS; k++) begin
         cl_req_ready[k] = (r_state == IDLE) && w_found && (w_winner == 3'(k));
      end
   end

   // Read beats go only to the owner; read data itself is broadcast unconditionally.
   always_comb begin
      cl_rd_valid = '0;
      for (int k = 0; k < NUM_CLIENTS; k++) begin
         cl_rd_valid[k] = (r_state == RD) && (r_owner == 3'(k)) && mem_rd_valid;
      end
   end

   // Memory-side data handshakes are gated by state so they stay quiet outside their phase.
   always_comb begin
      mem_rd_ready = (r_state == RD) && w_selRdReady;
      mem_wr_valid = (r_state == WR) && w_selWrValid;
      mem_wr_bits  = (r_state == WR) ? w_selWrBits : '0;
      w_rdBeat     = (r_state == RD) && mem_rd_valid && w_selRdReady;
      w_wrBeat     = (r_state == WR) && w_selWrValid;
   end

   assign cl_rd_bits     = mem_rd_bits;
   assign mem_req_valid  = (r_state == REQ);
   assign mem_req_opcode = r_op;
   assign mem_req_len    = r_len;
   assign mem_req_addr   = r_addr;
   assign busy           = (r_state != IDLE);
   assign grant_id       = (r_state == IDLE) ? 3'd0 : r_owner;

   // Main FSM: grant and latch in IDLE, issue in REQ, then count beats down to zero.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= IDLE;
         r_ptr   <= 3'd0;
         r_owner <= 3'd0;
         r_cnt   <= '0;
         r_op    <= 1'b0;
         r_len   <= '0;
         r_addr  <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_found) begin
                  r_owner <= w_winner;
                  r_op    <= w_winOp;
                  r_len   <= w_winLen;
                  r_addr  <= w_winAddr;
                  r_ptr   <= w_ptrNext;
                  r_state <= REQ;
               end
            end
            REQ: begin
               r_cnt   <= r_len;
               r_state <= r_op ? WR : RD;
            end
            RD: begin
               if (w_rdBeat) begin
                  if (r_cnt == '0) begin
                     r_state <= IDLE;
                  end else begin
                     r_cnt <= r_cnt - 1'b1;
                  end
               end
            end
            WR: begin
               if (w_wrBeat) begin
                  if (r_cnt == '0) begin
                     r_state <= IDLE;
                  end else begin
                     r_cnt <= r_cnt - 1'b1;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios for mem_arbiter with two clients,
// expected values worked out by hand from the arbiter's protocol.
module tb_mem_arbiter;

   localparam int N   = 2;
   localparam int LB  = 8;
   localparam int AB  = 64;
   localparam int DB  = 64;

   logic            clock;
   logic            reset;
   logic [N-1:0]    cl_req_valid;
   logic [N-1:0]    cl_req_ready;
   logic [N-1:0]    cl_req_opcode;
   logic [N*LB-1:0] cl_req_len;
   logic [N*AB-1:0] cl_req_addr;
   logic [N-1:0]    cl_wr_valid;
   logic [N*DB-1:0] cl_wr_bits;
   logic [N-1:0]    cl_rd_valid;
   logic [DB-1:0]   cl_rd_bits;
   logic [N-1:0]    cl_rd_ready;
   logic            mem_req_valid;
   logic            mem_req_opcode;
   logic [LB-1:0]   mem_req_len;
   logic [AB-1:0]   mem_req_addr;
   logic            mem_wr_valid;
   logic [DB-1:0]   mem_wr_bits;
   logic            mem_rd_valid;
   logic [DB-1:0]   mem_rd_bits;
   logic            mem_rd_ready;
   logic            busy;
   logic [2:0]      grant_id;

   int checks   = 0;
   int failures = 0;

   mem_arbiter #(
      .NUM_CLIENTS  (N),
      .MEM_LEN_BITS (LB),
      .MEM_ADDR_BITS(AB),
      .MEM_DATA_BITS(DB)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .cl_req_valid  (cl_req_valid),
      .cl_req_ready  (cl_req_ready),
      .cl_req_opcode (cl_req_opcode),
      .cl_req_len    (cl_req_len),
      .cl_req_addr   (cl_req_addr),
      .cl_wr_valid   (cl_wr_valid),
      .cl_wr_bits    (cl_wr_bits),
      .cl_rd_valid   (cl_rd_valid),
      .cl_rd_bits    (cl_rd_bits),
      .cl_rd_ready   (cl_rd_ready),
      .mem_req_valid (mem_req_valid),
      .mem_req_opcode(mem_req_opcode),
      .mem_req_len   (mem_req_len),
      .mem_req_addr  (mem_req_addr),
      .mem_wr_valid  (mem_wr_valid),
      .mem_wr_bits   (mem_wr_bits),
      .mem_rd_valid  (mem_rd_valid),
      .mem_rd_bits   (mem_rd_bits),
      .mem_rd_ready  (mem_rd_ready),
      .busy          (busy),
      .grant_id      (grant_id)
   );

   // 10 ns clock
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Hard stop in case a bounded loop is somehow bypassed
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Present a request on one client's request fields
   task automatic applyStimulus(input int idx, input logic op, input logic [LB-1:0] len,
                                input logic [AB-1:0] addr);
      cl_req_opcode[idx]           = op;
      cl_req_len[idx*LB +: LB]     = len;
      cl_req_addr[idx*AB +: AB]    = addr;
      cl_req_valid[idx]            = 1'b1;
   endtask

   initial begin
      int beats;
      logic sawReady;

      reset         = 1'b1;
      cl_req_valid  = '0;
      cl_req_opcode = '0;
      cl_req_len    = '0;
      cl_req_addr   = '0;
      cl_wr_valid   = '0;
      cl_wr_bits    = '0;
      cl_rd_ready   = '0;
      mem_rd_valid  = 1'b0;
      mem_rd_bits   = '0;

      tick();
      tick();
      checkOutput("reset_busy", 64'(busy), 64'd0);
      checkOutput("reset_grant", 64'(grant_id), 64'd0);
      checkOutput("reset_reqvalid", 64'(mem_req_valid), 64'd0);
      checkOutput("reset_wrvalid", 64'(mem_wr_valid), 64'd0);
      checkOutput("reset_rdready", 64'(mem_rd_ready), 64'd0);
      reset = 1'b0;
      tick();
      checkOutput("idle_noreq_ready", 64'(cl_req_ready), 64'd0);

      // Client 0 read, len 3 at 0x100
      $display("[TB] single read burst");
      applyStimulus(0, 1'b0, 8'd3, 64'h100);
      #1;
      checkOutput("a_ready", 64'(cl_req_ready), 64'b01);
      tick();
      cl_req_valid = '0;
      #1;
      checkOutput("a_reqvalid", 64'(mem_req_valid), 64'd1);
      checkOutput("a_opcode", 64'(mem_req_opcode), 64'd0);
      checkOutput("a_len", 64'(mem_req_len), 64'd3);
      checkOutput("a_addr", mem_req_addr, 64'h100);
      checkOutput("a_busy", 64'(busy), 64'd1);
      checkOutput("a_req_ready_zero", 64'(cl_req_ready), 64'd0);
      mem_rd_valid = 1'b1;
      mem_rd_bits  = 64'hA5A5_0000_1234_5678;
      cl_rd_ready  = 2'b11;
      tick();
      checkOutput("a_reqvalid_drop", 64'(mem_req_valid), 64'd0);
      checkOutput("a_rdvalid_owner", 64'(cl_rd_valid), 64'b01);
      checkOutput("a_rdbits", cl_rd_bits, 64'hA5A5_0000_1234_5678);
      beats = 0;
      for (int i = 0; i < 10 && busy; i++) begin
         if (cl_rd_valid === 2'b01 && mem_rd_ready === 1'b1) beats++;
         tick();
      end
      checkOutput("a_beats", 64'(beats), 64'd4);
      checkOutput("a_busy_end", 64'(busy), 64'd0);
      checkOutput("a_idle_rdvalid", 64'(cl_rd_valid), 64'd0);
      checkOutput("a_idle_rdready", 64'(mem_rd_ready), 64'd0);

      // Simultaneous requests after reset: client 0 first, client 1 right after
      $display("[TB] round robin");
      mem_rd_valid = 1'b0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      applyStimulus(0, 1'b0, 8'd0, 64'h200);
      applyStimulus(1, 1'b0, 8'd0, 64'h300);
      #1;
      checkOutput("b_ready0", 64'(cl_req_ready), 64'b01);
      tick();
      cl_req_valid[0] = 1'b0;
      mem_rd_valid    = 1'b1;
      #1;
      checkOutput("b_grant0", 64'(grant_id), 64'd0);
      checkOutput("b_ready_req", 64'(cl_req_ready), 64'd0);
      tick();
      checkOutput("b_rd0", 64'(cl_rd_valid), 64'b01);
      tick();
      checkOutput("b_idle_busy", 64'(busy), 64'd0);
      checkOutput("b_ready1", 64'(cl_req_ready), 64'b10);
      tick();
      cl_req_valid[1] = 1'b0;
      #1;
      checkOutput("b_grant1", 64'(grant_id), 64'd1);
      checkOutput("b_addr1", mem_req_addr, 64'h300);
      tick();
      checkOutput("b_rd1", 64'(cl_rd_valid), 64'b10);
      tick();
      mem_rd_valid = 1'b0;
      checkOutput("b_end", 64'(busy), 64'd0);

      // Client 1 single-beat write; client 0 wr_valid must be ignored
      $display("[TB] write owner isolation");
      cl_wr_bits[1*DB +: DB] = 64'hDEAD_BEEF;
      cl_wr_bits[0*DB +: DB] = 64'h1111_1111;
      applyStimulus(1, 1'b1, 8'd0, 64'h400);
      #1;
      checkOutput("c_ready1", 64'(cl_req_ready), 64'b10);
      tick();
      cl_req_valid = '0;
      #1;
      checkOutput("c_opcode", 64'(mem_req_opcode), 64'd1);
      checkOutput("c_grant", 64'(grant_id), 64'd1);
      tick();
      cl_wr_valid = 2'b01;
      #1;
      checkOutput("c_other_wr", 64'(mem_wr_valid), 64'd0);
      tick();
      checkOutput("c_still_busy", 64'(busy), 64'd1);
      cl_wr_valid = 2'b11;
      #1;
      checkOutput("c_wrvalid", 64'(mem_wr_valid), 64'd1);
      checkOutput("c_wrbits", mem_wr_bits, 64'hDEAD_BEEF);
      tick();
      checkOutput("c_idle", 64'(busy), 64'd0);
      checkOutput("c_idle_wrvalid", 64'(mem_wr_valid), 64'd0);
      cl_wr_valid = '0;

      // Client 0 read len 1 with ready held low for 5 cycles
      $display("[TB] read backpressure");
      applyStimulus(0, 1'b0, 8'd1, 64'h500);
      tick();
      cl_req_valid = '0;
      cl_rd_ready  = 2'b00;
      mem_rd_valid = 1'b1;
      tick();
      sawReady = 1'b0;
      for (int i = 0; i < 5; i++) begin
         if (mem_rd_ready !== 1'b0) sawReady = 1'b1;
         tick();
      end
      checkOutput("d_rdready_low", 64'(sawReady), 64'd0);
      checkOutput("d_busy_held", 64'(busy), 64'd1);
      cl_rd_ready = 2'b01;
      #1;
      beats = 0;
      for (int i = 0; i < 10 && busy; i++) begin
         if (mem_rd_valid && mem_rd_ready) beats++;
         tick();
      end
      checkOutput("d_beats", 64'(beats), 64'd2);
      checkOutput("d_busy_end", 64'(busy), 64'd0);

      // Reset in the middle of an 8-beat read; pointer must return to client 0
      $display("[TB] reset mid-burst");
      applyStimulus(0, 1'b0, 8'd7, 64'h700);
      tick();
      cl_req_valid = '0;
      tick();
      tick();
      reset = 1'b1;
      tick();
      checkOutput("e_busy", 64'(busy), 64'd0);
      checkOutput("e_rdvalid", 64'(cl_rd_valid), 64'd0);
      checkOutput("e_rdready", 64'(mem_rd_ready), 64'd0);
      checkOutput("e_len", 64'(mem_req_len), 64'd0);
      checkOutput("e_addr", mem_req_addr, 64'd0);
      checkOutput("e_grant", 64'(grant_id), 64'd0);
      reset        = 1'b0;
      mem_rd_valid = 1'b0;
      applyStimulus(0, 1'b0, 8'd0, 64'h800);
      applyStimulus(1, 1'b0, 8'd0, 64'h900);
      #1;
      checkOutput("e_ptr_reset", 64'(cl_req_ready), 64'b01);
      tick();
      cl_req_valid = '0;
      #1;
      checkOutput("e_addr_new", mem_req_addr, 64'h800);
      reset = 1'b1;
      tick();
      reset = 1'b0;

      // Maximum-length write: 256 beats
      $display("[TB] max length write");
      applyStimulus(0, 1'b1, 8'd255, 64'hA00);
      tick();
      cl_req_valid = '0;
      #1;
      checkOutput("f_len", 64'(mem_req_len), 64'd255);
      cl_wr_valid = 2'b01;
      tick();
      beats = 0;
      for (int i = 0; i < 300 && busy; i++) begin
         if (mem_wr_valid) beats++;
         tick();
      end
      checkOutput("f_beats", 64'(beats), 64'd256);
      checkOutput("f_busy", 64'(busy), 64'd0);
      checkOutput("f_wrvalid_idle", 64'(mem_wr_valid), 64'd0);
      cl_wr_valid = '0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
